// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives x,y,w,z through all 16 minterms of a
// four-input boolean block and collects one 16-bit truth table plus a
// ones-count for each of NUM_FUNCS function outputs.
// Optional build macro GOLDEN_CHECK_EN adds a golden_tt input and a
// registered per-function mismatch output evaluated when the sweep ends.
module truth_table_sweeper #(
  parameter int NUM_FUNCS     = 5,
  parameter int SETTLE_CYCLES = 1   // legal range 1..15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    x,
  output logic                    y,
  output logic                    w,
  output logic                    z,
  input  logic [NUM_FUNCS-1:0]    f_in,
  output logic [16*NUM_FUNCS-1:0] tt_out,
  output logic [5*NUM_FUNCS-1:0]  cnt_out,
  output logic                    tt_valid
`ifdef GOLDEN_CHECK_EN
  ,
  input  logic [16*NUM_FUNCS-1:0] golden_tt,
  output logic [NUM_FUNCS-1:0]    mismatch
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Settle counter value on the last SETTLE cycle of a minterm.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] settle_q, settle_d;
  logic       tt_valid_q;

  // accept: a start taken in IDLE (clears tables); sample_en: SAMPLE cycle.
  logic accept;
  logic sample_en;
  logic last_sample;

  // Next-state logic for the sweep sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    accept    = 1'b0;
    sample_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d    = 4'd0;
        settle_d = 4'd0;
        if (start) begin
          accept  = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        settle_d = settle_q + 4'd1;
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        sample_en = 1'b1;
        settle_d  = 4'd0;
        if (idx_q == 4'd15) begin
          idx_d   = 4'd0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        idx_d   = 4'd0;
        state_d = ST_IDLE;
      end
      default: begin
        idx_d    = 4'd0;
        settle_d = 4'd0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  assign last_sample = sample_en && (idx_q == 4'd15);

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= 4'd0;
      settle_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
    end
  end

  // tt_valid rises together with done and stays up until the next sweep.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      tt_valid_q <= 1'b0;
    end else if (last_sample) begin
      tt_valid_q <= 1'b1;
    end
  end

  // Per-function truth table, ones-count and optional golden comparison.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FUNCS; gi++) begin : g_func
      logic [15:0] tt_q;
      logic [4:0]  cnt_q;

      // Capture f_in into the minterm's bit; count can reach 16 at most.
      always_ff @(posedge clk) begin
        if (rst || accept) begin
          tt_q  <= 16'd0;
          cnt_q <= 5'd0;
        end else if (sample_en) begin
          tt_q[idx_q] <= f_in[gi];
          cnt_q       <= cnt_q + {4'd0, f_in[gi]};
        end
      end

      assign tt_out[16*gi +: 16] = tt_q;
      assign cnt_out[5*gi +: 5]  = cnt_q;

`ifdef GOLDEN_CHECK_EN
      logic mismatch_q;

      // Compare the finished table (idx 15 already captured) in DONE.
      always_ff @(posedge clk) begin
        if (rst || accept) begin
          mismatch_q <= 1'b0;
        end else if (state_q == ST_DONE) begin
          mismatch_q <= (tt_q != golden_tt[16*gi +: 16]);
        end
      end

      assign mismatch[gi] = mismatch_q;
`endif
    end
  endgenerate

  assign busy     = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done     = (state_q == ST_DONE);
  assign tt_valid = tt_valid_q;
  assign x        = idx_q[3];
  assign y        = idx_q[2];
  assign w        = idx_q[1];
  assign z        = idx_q[0];

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Testbench for truth_table_sweeper: emulates the evaluated boolean block
// from per-function truth tables (or fixed expressions) and checks the
// collected tables, counts, sweep order and timing.
module tb_truth_table_sweeper;

  localparam int NF = 5;
  localparam int SC = 1;
  localparam int DONE_LAT = 16 * (SC + 1) + 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic             busy;
  logic             done;
  logic             x, y, w, z;
  logic [NF-1:0]    f_in;
  logic [16*NF-1:0] tt_out;
  logic [5*NF-1:0]  cnt_out;
  logic             tt_valid;
`ifdef GOLDEN_CHECK_EN
  logic [16*NF-1:0] golden_tt;
  logic [NF-1:0]    mismatch;
`endif

  int checks;
  int failures;

  // mode 0: f_in from func_tt tables; mode 1: fixed expressions.
  int          mode;
  logic [15:0] func_tt [NF];
  logic [15:0] row;
  logic [3:0]  cur_idx;

  assign cur_idx = {x, y, w, z};

  truth_table_sweeper #(
    .NUM_FUNCS    (NF),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .x        (x),
    .y        (y),
    .w        (w),
    .z        (z),
    .f_in     (f_in),
    .tt_out   (tt_out),
    .cnt_out  (cnt_out),
    .tt_valid (tt_valid)
`ifdef GOLDEN_CHECK_EN
    ,
    .golden_tt(golden_tt),
    .mismatch (mismatch)
`endif
  );

  always #5 clk = ~clk;

  // Behaviour of the evaluated four-input block.
  always_comb begin
    f_in = '0;
    row  = '0;
    if (mode == 0) begin
      for (int k = 0; k < NF; k++) begin
        row     = func_tt[k];
        f_in[k] = row[cur_idx];
      end
    end else begin
      f_in[0] = z;
      f_in[1] = x;
      f_in[2] = x & y & w & z;
      f_in[3] = 1'b0;
      f_in[4] = y ^ w;
    end
  end

  // Pulse start, follow the sweep cycle by cycle, report done's cycle.
  task automatic run_sweep(input int repulse_at, output int done_at);
    int c;
    done_at = -1;
    @(negedge clk);
    start = 1'b1;
    c = 0;
    while (c < 200) begin
      @(negedge clk);
      c++;
      start = (c == repulse_at);
      if (c == 1) begin
        checks++;
        if (tt_valid !== 1'b0 || tt_out !== '0 || cnt_out !== '0) begin
          failures++;
          $display("FAIL clear_on_start tt_valid=%b tt_out=%h cnt_out=%h required 0/0/0",
                   tt_valid, tt_out, cnt_out);
        end
      end
      if (done === 1'b1) begin
        done_at = c;
        break;
      end
      checks++;
      if (busy !== 1'b1 || cur_idx !== 4'((c - 1) / (SC + 1))) begin
        failures++;
        $display("FAIL sweep_order cycle=%0d busy=%b idx=%0d required busy=1 idx=%0d",
                 c, busy, cur_idx, (c - 1) / (SC + 1));
      end
    end
    start = 1'b0;
    checks++;
    if (done_at != DONE_LAT) begin
      failures++;
      $display("FAIL done_latency got=%0d required=%0d", done_at, DONE_LAT);
    end
    if (done_at > 0) begin
      checks++;
      if (busy !== 1'b0 || cur_idx !== 4'd0 || tt_valid !== 1'b1) begin
        failures++;
        $display("FAIL done_cycle busy=%b idx=%0d tt_valid=%b required 0/0/1",
                 busy, cur_idx, tt_valid);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || tt_valid !== 1'b1) begin
        failures++;
        $display("FAIL after_done done=%b busy=%b tt_valid=%b required 0/0/1",
                 done, busy, tt_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, x, y, w, z, tt_valid} !== 7'd0 || tt_out !== '0 || cnt_out !== '0) begin
      failures++;
      $display("FAIL reset_state ctl=%b tt_out=%h cnt_out=%h required all 0",
               {busy, done, x, y, w, z, tt_valid}, tt_out, cnt_out);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  task automatic test_all_ones();
    int d;
    mode = 0;
    for (int k = 0; k < NF; k++) func_tt[k] = 16'hFFFF;
    run_sweep(0, d);
    for (int k = 0; k < NF; k++) begin
      checks++;
      if (tt_out[16*k +: 16] !== 16'hFFFF || cnt_out[5*k +: 5] !== 5'd16) begin
        failures++;
        $display("FAIL all_ones f%0d tt=%h cnt=%0d required ffff/16",
                 k, tt_out[16*k +: 16], cnt_out[5*k +: 5]);
      end
    end
    $display("all_ones sweep done_at=%0d", d);
  endtask

  task automatic test_known_functions();
    int          d;
    logic [15:0] exp_tt [NF];
    logic [4:0]  exp_cnt [NF];
    exp_tt[0] = 16'hAAAA; exp_cnt[0] = 5'd8;
    exp_tt[1] = 16'hFF00; exp_cnt[1] = 5'd8;
    exp_tt[2] = 16'h8000; exp_cnt[2] = 5'd1;
    exp_tt[3] = 16'h0000; exp_cnt[3] = 5'd0;
    exp_tt[4] = 16'h3C3C; exp_cnt[4] = 5'd8;
    mode = 1;
    run_sweep(0, d);
    for (int k = 0; k < NF; k++) begin
      checks++;
      if (tt_out[16*k +: 16] !== exp_tt[k] || cnt_out[5*k +: 5] !== exp_cnt[k]) begin
        failures++;
        $display("FAIL known_func f%0d tt=%h cnt=%0d required %h/%0d",
                 k, tt_out[16*k +: 16], cnt_out[5*k +: 5], exp_tt[k], exp_cnt[k]);
      end
    end
    $display("known_functions sweep done_at=%0d", d);
  endtask

  task automatic test_random(input int repulse_at, input string tag);
    int d;
    mode = 0;
    for (int k = 0; k < NF; k++) func_tt[k] = 16'($urandom);
    run_sweep(repulse_at, d);
    for (int k = 0; k < NF; k++) begin
      checks++;
      if (tt_out[16*k +: 16] !== func_tt[k] ||
          cnt_out[5*k +: 5] !== 5'($countones(func_tt[k]))) begin
        failures++;
        $display("FAIL %s f%0d tt=%h cnt=%0d required %h/%0d", tag, k,
                 tt_out[16*k +: 16], cnt_out[5*k +: 5], func_tt[k], $countones(func_tt[k]));
      end
    end
    $display("%s sweep done_at=%0d", tag, d);
  endtask

  task automatic test_reset_mid();
    bit found;
    mode = 0;
    for (int k = 0; k < NF; k++) func_tt[k] = 16'($urandom);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cur_idx == 4'd7) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_minterm7 idx=%0d required 7", cur_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, x, y, w, z, tt_valid} !== 7'd0 || tt_out !== '0 || cnt_out !== '0) begin
      failures++;
      $display("FAIL reset_mid ctl=%b tt_out=%h cnt_out=%h required all 0",
               {busy, done, x, y, w, z, tt_valid}, tt_out, cnt_out);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_idle busy=%b required 0", busy);
    end
    $display("reset_mid applied at minterm 7");
  endtask

  task automatic test_rst_start_together();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || tt_valid !== 1'b0 || tt_out !== '0) begin
      failures++;
      $display("FAIL rst_wins busy=%b tt_valid=%b tt_out=%h required 0/0/0",
               busy, tt_valid, tt_out);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_wins_idle busy=%b required 0", busy);
    end
    $display("rst_start_together checked");
  endtask

`ifdef GOLDEN_CHECK_EN
  task automatic test_golden();
    int d;
    mode = 1;
    golden_tt = {16'h3C3C, 16'h0000, 16'h8000, 16'hFFFF, 16'hAAAA};
    run_sweep(0, d);
    checks++;
    if (mismatch !== 5'b00010) begin
      failures++;
      $display("FAIL golden_mismatch got=%b required=%b", mismatch, 5'b00010);
    end
    $display("golden sweep done_at=%0d mismatch=%b", d, mismatch);
  endtask
`endif

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    start    = 1'b0;
    mode     = 0;
    checks   = 0;
    failures = 0;
    for (int k = 0; k < NF; k++) func_tt[k] = 16'h0000;
`ifdef GOLDEN_CHECK_EN
    golden_tt = '0;
`endif
    test_reset();
    test_all_ones();
    test_known_functions();
    test_random(0, "random_a");
    test_random(0, "random_b");
    test_random(10, "restart_ignored");
    test_random(0, "back_to_back");
    test_reset_mid();
    test_random(0, "after_reset");
    test_rst_start_together();
`ifdef GOLDEN_CHECK_EN
    test_golden();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
